// File: rtl/cvxif_result_queue.sv
// CVXIF writeback queue: pairs snooped issue rd tags with posit coprocessor results, in order.
// Optional NaR exception flag per entry is enabled by defining RESULT_QUEUE_NAR_EXC_EN.
module cvxif_result_queue #(
    parameter int DEPTH = 4,
    parameter int PAU_N = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_ready,
    input  logic                     issue_resp_accept,
    input  logic [31:0]              issue_req_instr,
    input  logic                     pau_result_valid,
    output logic                     pau_result_ready,
    input  logic [31:0]              pau_result_data,
    output logic                     x_result_valid,
    input  logic                     x_result_ready,
    output logic [31:0]              x_result_data,
    output logic [4:0]               x_result_rd,
    output logic                     x_result_we,
`ifdef RESULT_QUEUE_NAR_EXC_EN
    output logic                     x_result_exc,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tag_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // ---------------- rd tag FIFO ----------------
    logic [4:0]    r_tag_mem [DEPTH];
    logic [AW-1:0] r_tag_wptr;
    logic [AW-1:0] r_tag_rptr;
    logic [CW-1:0] r_tag_cnt;
    logic          r_tag_overflow;

    logic w_issue_fire;
    logic w_tag_full;
    logic w_tag_empty;
    logic w_tag_push;
    logic w_tag_pop;
    logic w_tag_drop;
    logic [4:0] w_issue_rd;
    logic [4:0] w_head_tag;
    logic w_unused_instr;

    assign w_issue_fire   = issue_valid & issue_ready & issue_resp_accept;
    assign w_issue_rd     = issue_req_instr[11:7];
    assign w_unused_instr = ^{issue_req_instr[31:12], issue_req_instr[6:0]};
    assign w_tag_full     = (r_tag_cnt == FULL_CNT);
    assign w_tag_empty    = (r_tag_cnt == '0);
    assign w_head_tag     = r_tag_mem[r_tag_rptr];

    // A full tag FIFO still accepts a tag when the head is consumed in the same cycle.
    assign w_tag_pop  = pau_result_valid & pau_result_ready;
    assign w_tag_push = w_issue_fire & (~w_tag_full | w_tag_pop);
    assign w_tag_drop = w_issue_fire & w_tag_full & ~w_tag_pop;

    always_ff @(posedge clk) begin
        if (w_tag_push) begin
            r_tag_mem[r_tag_wptr] <= w_issue_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wptr     <= '0;
            r_tag_rptr     <= '0;
            r_tag_cnt      <= '0;
            r_tag_overflow <= 1'b0;
        end else begin
            if (w_tag_push) begin
                r_tag_wptr <= r_tag_wptr + 1'b1;
            end
            if (w_tag_pop) begin
                r_tag_rptr <= r_tag_rptr + 1'b1;
            end
            case ({w_tag_push, w_tag_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
            if (w_tag_drop) begin
                r_tag_overflow <= 1'b1;
            end
        end
    end

    // ---------------- result FIFO ----------------
    logic [31:0]   r_res_data [DEPTH];
    logic [4:0]    r_res_rd   [DEPTH];
    logic [AW-1:0] r_res_wptr;
    logic [AW-1:0] r_res_rptr;
    logic [CW-1:0] r_count;

    logic w_res_full;
    logic w_res_push;
    logic w_res_pop;

    // Full is judged before any same-cycle pop, so a full queue never falls through.
    assign w_res_full       = (r_count == FULL_CNT);
    assign pau_result_ready = ~w_tag_empty & ~w_res_full;
    assign w_res_push       = w_tag_pop;
    assign x_result_valid   = (r_count != '0);
    assign w_res_pop        = x_result_valid & x_result_ready;

`ifdef RESULT_QUEUE_NAR_EXC_EN
    localparam logic [PAU_N-1:0] NAR = {1'b1, {(PAU_N-1){1'b0}}};
    logic r_res_exc [DEPTH];
    logic w_is_nar;

    assign w_is_nar = (pau_result_data[PAU_N-1:0] == NAR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res_data[i] <= '0;
                r_res_rd[i]   <= '0;
`ifdef RESULT_QUEUE_NAR_EXC_EN
                r_res_exc[i]  <= 1'b0;
`endif
            end
            r_res_wptr <= '0;
            r_res_rptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_res_push) begin
                r_res_data[r_res_wptr] <= pau_result_data;
                r_res_rd[r_res_wptr]   <= w_head_tag;
`ifdef RESULT_QUEUE_NAR_EXC_EN
                r_res_exc[r_res_wptr]  <= w_is_nar;
`endif
                r_res_wptr <= r_res_wptr + 1'b1;
            end
            if (w_res_pop) begin
                r_res_rptr <= r_res_rptr + 1'b1;
            end
            case ({w_res_push, w_res_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields come straight from storage; they hold while the core stalls.
    assign x_result_data = r_res_data[r_res_rptr];
    assign x_result_rd   = r_res_rd[r_res_rptr];
`ifdef RESULT_QUEUE_NAR_EXC_EN
    assign x_result_exc  = r_res_exc[r_res_rptr];
    assign x_result_we   = (x_result_rd != 5'd0) & ~x_result_exc;
`else
    assign x_result_we   = (x_result_rd != 5'd0);
`endif

    assign count        = r_count;
    assign tag_overflow = r_tag_overflow;

endmodule

// File: doc/cvxif_result_queue.md
# cvxif_result_queue

Writeback stage directly downstream of the posit coprocessor on the CVXIF path. It snoops the issue handshake to capture each accepted instruction's destination register (rd, instr[11:7]). It pairs that rd, in order, with the result the coprocessor produces, and buffers the paired {rd, data} in a small FIFO. This decouples the coprocessor's result handshake from core writeback stalls.

## Interface
Parameters:
- DEPTH, 4: entries in both the rd-tag FIFO and the result FIFO; power of two, ≥2.
- PAU_N, 32: posit width; low PAU_N bits of result data are posit-significant.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high.
- issue_valid  in  1  snooped core issue request valid.
- issue_ready  in  1  snooped coprocessor issue ready.
- issue_resp_accept  in  1  snooped coprocessor accept.
- issue_req_instr  in  32  snooped instruction word.
- pau_result_valid  in  1  coprocessor result valid.
- pau_result_ready  out  1  result accepted from coprocessor.
- pau_result_data  in  32  coprocessor result.
- x_result_valid  out  1  result available to core.
- x_result_ready  in  1  core takes result.
- x_result_data  out  32  result data.
- x_result_rd  out  5  destination register.
- x_result_we  out  1  write enable; 1 iff rd ≠ 0.
- x_result_exc  out  1  NaR flag; present only with RESULT_QUEUE_NAR_EXC_EN.
- count  out  $clog2(DEPTH)+1  result FIFO occupancy.
- tag_overflow  out  1  sticky: issue accepted while tag FIFO full.

## Operation
- Tag push: on issue_valid & issue_ready & issue_resp_accept, push issue_req_instr[11:7] to the tag FIFO.
- If the tag FIFO is full with no pop that cycle, drop the tag and set tag_overflow until rst.
- pau_result_ready = tag FIFO non-empty & result FIFO not full. Combinational from internal state only; independent of pau_result_valid.
- On a PAU handshake (pau_result_valid & pau_result_ready):
  - pop the head tag;
  - push {tag, pau_result_data, exc} to the result FIFO.
- A result with no outstanding tag is never accepted and stalls until a tag arrives.
- Result FIFO: x_result_valid = count ≠ 0. Head fields are driven from registered storage. Pop on x_result_valid & x_result_ready.
- Push/pop in the same cycle: count unchanged. The full check uses pre-pop state, so a full FIFO does not accept that cycle (no fall-through).
- Tag FIFO, push and pop in the same cycle: both happen, including when full or when it holds exactly one entry.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy counters run 0..DEPTH.
- Ordering is strict FIFO: the n-th accepted instruction pairs with the n-th accepted result.

## Timing
- Reset values: pau_result_ready=0, x_result_valid=0, x_result_data=0, x_result_rd=0, x_result_we=0, x_result_exc=0, count=0, tag_overflow=0. Both FIFOs empty, pointers 0.
- Tag written at cycle T is usable for pairing at T+1. No same-cycle issue→result bypass.
- Result accepted at edge T: x_result_valid=1 and fields valid after T, i.e. in cycle T+1 (one-cycle latency).
- x_result_* fields stay stable while x_result_valid=1 and x_result_ready=0.
- Throughput: one result per cycle in and out.
- rst mid-operation flushes all entries and outstanding tags on the next edge. Results in flight in the coprocessor are not recovered.

## Configuration
- RESULT_QUEUE_NAR_EXC_EN:
  - Defined: an exc bit is stored per entry, set when pau_result_data[PAU_N-1:0] == {1'b1, {PAU_N-1{1'b0}}} (posit NaR). The x_result_exc port exists, and x_result_we is forced to 0 for NaR results.
  - Undefined: no exc storage, no x_result_exc port, and x_result_we depends only on rd.

## Test plan
- Issue instr 0x0000_20FB (rd=1) → 3 cycles later pau_result_valid with data 0x4000_0000 → next cycle x_result_valid=1, rd=1, data=0x4000_0000, we=1.
- Issue rd=0, then result → x_result_we=0, x_result_valid=1, count=1 until popped.
- x_result_ready=0, push 4 results with rd=1..4 → count=4, pau_result_ready=0. Pop one → the next result is accepted the following cycle. Outputs are in order 1,2,3,4.
- pau_result_valid=1 with no prior issue → pau_result_ready stays 0. Issue rd=5 → result accepted one cycle later, with rd=5.
- 5 issues with no results, DEPTH=4 → tag_overflow=1 and stays 1. rst → all outputs 0, count=0.
- With macro: result 0x8000_0000 → x_result_exc=1, x_result_we=0. Result 0x0000_0000 → exc=0.
